twi_reg_bank: RTL
=================

# twi_reg_bank

Byte-level register bank behind the TWI slave front end. Consumes received bytes, interprets the first byte after each START as a register pointer and later bytes as auto-incrementing register writes. Supplies the byte the slave transmits on master reads. Crosses all TWI-domain events into the system clock domain and exposes the register contents to the rest of the FPGA.

## Interface
- `NREGS`, default 16: number of 8-bit registers; power of two, 2..256. `AW = log2(NREGS)`.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  last byte received by the slave; stable from its toggle until the next byte completes.
- `rx_toggle`  in  1  TWI-domain level; inverts once per received data/pointer byte.
- `start_toggle`  in  1  TWI-domain level; inverts once per START or repeated START addressed to this slave.
- `tx_ack_toggle`  in  1  TWI-domain level; inverts each time the slave latches `tx_data` for transmission.
- `tx_data`  out  8  byte offered to the slave's transmit input; registered.
- `regs_flat`  out  NREGS*8  all registers; register k occupies bits [8k+7:8k].
- `wr_strobe`  out  1  one-cycle pulse when a register is written.
- `wr_addr`  out  AW  register written; valid while `wr_strobe` is high.

## Operation
- Synchronisers: each toggle input feeds 2 flops, then a third flop for edge detection. An event is any difference between flop 2 and flop 3.
- Reset-release mask: a 2-bit counter holds event detection off for the first 3 clk edges after `rst_n` rises. The chains fill but produce no events.
- State machine, reset to IDLE:
  - IDLE: ignores rx events. A start event moves to PTR.
  - PTR: an rx event sets `ptr <= rx_data[AW-1:0]`, ignoring upper bits, and moves to DATA.
  - DATA: an rx event writes `rx_data` to `regs[ptr]` and pulses `wr_strobe` with `wr_addr = ptr`. Then `ptr <= ptr+1` modulo NREGS.
  - A start event in any state moves to PTR. No STOP input exists; the bank stays in DATA until the next start.
- Read path:
  - `tx_data <= regs[ptr]` every cycle.
  - A tx_ack event in any state sets `ptr <= ptr+1` modulo NREGS.
- Simultaneous events in one cycle:
  - start + rx: start first, so the byte is taken as the pointer (state ends in DATA, no write).
  - rx + tx_ack: the rx action applies and ptr advances by 1 only.
  - start + tx_ack: go to PTR and ptr still advances.
- A write to `regs[ptr]` updates `tx_data` on the next cycle.

## Timing
- Reset values: regs all 0x00, `ptr` 0, state IDLE, `tx_data` 0x00, `wr_strobe` 0, `wr_addr` 0, mask counter 0.
- Event latency: input toggles before clk edge n, so the event is detected at edge n+2 and acted on at edge n+3. `rx_data` is sampled at that same edge. It is guaranteed stable for ≥8 SCL periods, far above 3 clk.
- Write latency: `wr_strobe`, `wr_addr` and `regs_flat` update at edge n+3. `tx_data` reflects the new register or pointer at edge n+4.
- Back-to-back events on one toggle must be ≥3 clk apart; closer events are lost. The TWI rate guarantees this with clk ≥ 8× SCL.
- Reset mid-transaction returns all state to reset values immediately. Pending events are discarded by the mask.

## Test plan
- Reset with all toggles at 1, release → no `wr_strobe` and state stays IDLE for 10 cycles; `tx_data`=0x00.
- start, rx 0x03, rx 0xA5, rx 0x5A → regs[3]=0xA5, regs[4]=0x5A, two `wr_strobe` pulses with `wr_addr` 3 then 4; each strobe 3 clk after its toggle.
- start, rx 0x0F, rx 0x11, rx 0x22 (NREGS=16) → regs[15]=0x11, regs[0]=0x22 (wrap); pointer byte 0x1F also selects 15.
- Preload regs[6]=0x77, regs[7]=0x88; start, rx 0x06, then tx_ack twice → `tx_data`=0x77, then 0x88, then regs[8].
- rx toggles in IDLE (no start) → no writes; start and rx toggled same edge with rx_data 0x02, then rx 0x99 → regs[2]=0x99.
- Assert `rst_n` low mid-write sequence → all outputs at reset values within the same cycle; release, resume sequence → correct writes.

Source files
------------

// File: rtl/twi_reg_bank.sv
// twi_reg_bank: pointer/auto-increment register bank fed by TWI-domain toggle events.
// Each event is synchronised and registered, then applied three clocks after its toggle.
module twi_reg_bank #(
    parameter int NREGS = 16,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_toggle,
    input  logic             start_toggle,
    input  logic             tx_ack_toggle,
    output logic [7:0]       tx_data,
    output logic [NREGS*8-1:0] regs_flat,
    output logic             wr_strobe,
    output logic [AW-1:0]    wr_addr
);
    typedef enum logic [1:0] {IDLE, PTR, DATA} state_t;

    logic [2:0]    r_rx_sync, r_st_sync, r_ack_sync;
    logic [1:0]    r_mask_cnt;
    logic          r_ev_rx, r_ev_st, r_ev_ack;
    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic [7:0]    r_regs [NREGS];
    logic          w_wr;
    logic          w_mask_done;

    assign w_mask_done = r_mask_cnt == 2'd3;

    // bit 0/1 synchronise, bit 2 is the edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync  <= '0;
            r_st_sync  <= '0;
            r_ack_sync <= '0;
            r_mask_cnt <= '0;
            r_ev_rx    <= 1'b0;
            r_ev_st    <= 1'b0;
            r_ev_ack   <= 1'b0;
        end else begin
            r_rx_sync  <= {r_rx_sync[1:0], rx_toggle};
            r_st_sync  <= {r_st_sync[1:0], start_toggle};
            r_ack_sync <= {r_ack_sync[1:0], tx_ack_toggle};
            r_mask_cnt <= w_mask_done ? r_mask_cnt : r_mask_cnt + 2'd1;
            r_ev_rx    <= w_mask_done & (r_rx_sync[1] ^ r_rx_sync[2]);
            r_ev_st    <= w_mask_done & (r_st_sync[1] ^ r_st_sync[2]);
            r_ev_ack   <= w_mask_done & (r_ack_sync[1] ^ r_ack_sync[2]);
        end
    end

    // a start coinciding with rx makes that byte the pointer
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_wr        = 1'b0;
        if (r_ev_rx && (r_ev_st || r_state == PTR)) begin
            w_ptr_nxt   = rx_data[AW-1:0];
            w_state_nxt = DATA;
        end else begin
            if (r_ev_st)
                w_state_nxt = PTR;
            if (r_ev_rx && r_state == DATA) begin
                w_wr      = 1'b1;
                w_ptr_nxt = r_ptr + 1'b1;
            end else if (r_ev_ack) begin
                w_ptr_nxt = r_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            tx_data   <= 8'h00;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            tx_data   <= r_regs[r_ptr];
            wr_strobe <= w_wr;
            if (w_wr) begin
                r_regs[r_ptr] <= rx_data;
                wr_addr       <= r_ptr;
            end
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs_flat[8*k +: 8] = r_regs[k];
    end
endmodule
